// File: rtl/cond_unit.sv
// cond_unit - condition evaluation and NZCV flag storage behind the ALU.
// Holds the architectural flags, evaluates the instruction condition field
// against them and gates the register-file, memory and PC write enables.
// Optional feature macro: COND_QFLAG_EN adds a sticky Q flag with its
// q_set / msr_data_q inputs and qflag output.
module cond_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [2:0] flag_w,
  input  logic       msr_we,
  input  logic [3:0] msr_data,
  input  logic       reg_write,
  input  logic       mem_write,
  input  logic       pc_src,
`ifdef COND_QFLAG_EN
  input  logic       q_set,
  input  logic       msr_data_q,
  output logic       qflag,
`endif
  output logic       cond_ex,
  output logic       reg_write_g,
  output logic       mem_write_g,
  output logic       pc_src_g,
  output logic [3:0] flags,
  output logic       carry_out
);

  logic [3:0] r_flags;
  logic [3:0] w_flagsNext;
  logic       w_condPass;
  logic       w_commit;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Decode the condition field against the flags stored before this instruction.
  always_comb begin
    w_condPass = 1'b0;
    case (cond)
      4'b0000: w_condPass = w_z;
      4'b0001: w_condPass = !w_z;
      4'b0010: w_condPass = w_c;
      4'b0011: w_condPass = !w_c;
      4'b0100: w_condPass = w_n;
      4'b0101: w_condPass = !w_n;
      4'b0110: w_condPass = w_v;
      4'b0111: w_condPass = !w_v;
      4'b1000: w_condPass = w_c && !w_z;
      4'b1001: w_condPass = !w_c || w_z;
      4'b1010: w_condPass = (w_n == w_v);
      4'b1011: w_condPass = (w_n != w_v);
      4'b1100: w_condPass = !w_z && (w_n == w_v);
      4'b1101: w_condPass = w_z || (w_n != w_v);
      4'b1110: w_condPass = 1'b1;
      default: w_condPass = 1'b0;
    endcase
  end

  // A live instruction whose condition passed is the only thing allowed to commit.
  assign w_commit    = instr_valid && w_condPass;
  assign cond_ex     = w_commit;
  assign reg_write_g = reg_write && w_commit;
  assign mem_write_g = mem_write && w_commit;
  assign pc_src_g    = pc_src && w_commit;

  // Select the next flag value: MSR overrides, otherwise per-group S-suffix updates.
  always_comb begin
    w_flagsNext = r_flags;
    if (w_commit) begin
      if (msr_we) begin
        w_flagsNext = msr_data;
      end else begin
        if (flag_w[2]) begin
          w_flagsNext[3:2] = alu_flags[3:2];
        end
        if (flag_w[1]) begin
          w_flagsNext[1] = alu_flags[1];
        end
        if (flag_w[0]) begin
          w_flagsNext[0] = alu_flags[0];
        end
      end
    end
  end

  // NZCV register; reset wins over any write pending in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= FLAG_RST;
    end else begin
      r_flags <= w_flagsNext;
    end
  end

  assign flags     = r_flags;
  assign carry_out = r_flags[1];

`ifdef COND_QFLAG_EN
  logic r_qflag;

  // Sticky saturation flag: set by q_set, only MSR or reset can clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qflag <= 1'b0;
    end else if (w_commit && msr_we) begin
      r_qflag <= msr_data_q;
    end else if (w_commit && q_set) begin
      r_qflag <= 1'b1;
    end
  end

  assign qflag = r_qflag;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit - self-checking bench for cond_unit.
// A flag model runs beside the DUT and is compared every mid-cycle, with
// directed literal checks pinning the model at the interesting points.
module tb_cond_unit;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [2:0] flag_w;
  logic       msr_we;
  logic [3:0] msr_data;
  logic       reg_write;
  logic       mem_write;
  logic       pc_src;
  logic       cond_ex;
  logic       reg_write_g;
  logic       mem_write_g;
  logic       pc_src_g;
  logic [3:0] flags;
  logic       carry_out;
`ifdef COND_QFLAG_EN
  logic       q_set;
  logic       msr_data_q;
  logic       qflag;
`endif

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 0;
  logic [3:0] modelFlags;

  cond_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .cond       (cond),
    .alu_flags  (alu_flags),
    .flag_w     (flag_w),
    .msr_we     (msr_we),
    .msr_data   (msr_data),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .pc_src     (pc_src),
`ifdef COND_QFLAG_EN
    .q_set      (q_set),
    .msr_data_q (msr_data_q),
    .qflag      (qflag),
`endif
    .cond_ex    (cond_ex),
    .reg_write_g(reg_write_g),
    .mem_write_g(mem_write_g),
    .pc_src_g   (pc_src_g),
    .flags      (flags),
    .carry_out  (carry_out)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural meaning of a condition: even codes test a predicate, odd
  // codes test its inverse; 1111 is never-execute.
  function automatic bit modelCond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  // Model of the flag register as the instruction set describes it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelFlags <= 4'b0000;
    end else if (instr_valid && modelCond(cond, modelFlags)) begin
      if (msr_we) begin
        modelFlags <= msr_data;
      end else begin
        modelFlags <= {flag_w[2] ? alu_flags[3:2] : modelFlags[3:2],
                       flag_w[1] ? alu_flags[1]   : modelFlags[1],
                       flag_w[0] ? alu_flags[0]   : modelFlags[0]};
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      logic expEx;
      expEx = instr_valid && modelCond(cond, modelFlags);
      checkOutput("flags", flags, modelFlags);
      checkOutput("carry_out", {3'b0, carry_out}, {3'b0, modelFlags[1]});
      checkOutput("cond_ex", {3'b0, cond_ex}, {3'b0, expEx});
      checkOutput("reg_write_g", {3'b0, reg_write_g}, {3'b0, reg_write && expEx});
      checkOutput("mem_write_g", {3'b0, mem_write_g}, {3'b0, mem_write && expEx});
      checkOutput("pc_src_g", {3'b0, pc_src_g}, {3'b0, pc_src && expEx});
    end
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [2:0] fw,
                               input logic [3:0] af, input logic mw, input logic [3:0] md);
    instr_valid = v;
    cond        = c;
    flag_w      = fw;
    alu_flags   = af;
    msr_we      = mw;
    msr_data    = md;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'b1110, 3'b000, 4'b0000, 1'b0, 4'b0000);
    reg_write = 1'b0;
    mem_write = 1'b0;
    pc_src    = 1'b0;
  endtask

  task automatic setFlags(input logic [3:0] v);
    idle();
    applyStimulus(1'b1, 4'b1110, 3'b000, 4'b0000, 1'b1, v);
    step();
    idle();
  endtask

  initial begin
    logic [3:0] sweepSet [6];
    sweepSet = '{4'b0000, 4'b1000, 4'b0001, 4'b1001, 4'b0110, 4'b0010};
`ifdef COND_QFLAG_EN
    q_set      = 1'b0;
    msr_data_q = 1'b0;
`endif
    rst_n = 1'b0;
    idle();
    repeat (2) step();
    rst_n = 1'b1;
    checkEn = 1'b1;

    // Mid-cycle asynchronous reset after loading non-zero flags
    setFlags(4'b1111);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_flags", flags, 4'b0000);
    checkOutput("reset_carry", {3'b0, carry_out}, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b0000);
    #1;
    checkOutput("reset_eq", {3'b0, cond_ex}, 4'b0000);
    cond = 4'b1110;
    #1;
    checkOutput("reset_al", {3'b0, cond_ex}, 4'b0001);
    step();
    idle();
    rst_n = 1'b1;

    // Arithmetic update then dependent EQ
    setFlags(4'b0000);
    applyStimulus(1'b1, 4'b1110, 3'b111, 4'b0100, 1'b0, 4'b0000);
    step();
    applyStimulus(1'b1, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b0000);
    reg_write = 1'b1;
    @(negedge clk);
    checkOutput("arith_flags", flags, 4'b0100);
    checkOutput("eq_reg_write_g", {3'b0, reg_write_g}, 4'b0001);
    step();

    // Logical update holds V
    setFlags(4'b0001);
    applyStimulus(1'b1, 4'b1110, 3'b110, 4'b1010, 1'b0, 4'b0000);
    step();
    idle();
    @(negedge clk);
    checkOutput("logical_flags", flags, 4'b1011);
    step();

    // Failed condition writes nothing
    setFlags(4'b0000);
    applyStimulus(1'b1, 4'b0000, 3'b111, 4'b1111, 1'b0, 4'b0000);
    mem_write = 1'b1;
    @(negedge clk);
    checkOutput("failed_mem_write_g", {3'b0, mem_write_g}, 4'b0000);
    step();
    idle();
    @(negedge clk);
    checkOutput("failed_flags", flags, 4'b0000);
    step();

    // Sweep every condition over several flag patterns
    foreach (sweepSet[k]) begin
      setFlags(sweepSet[k]);
      reg_write = 1'b1;
      mem_write = 1'b1;
      pc_src    = 1'b1;
      for (int c = 0; c < 16; c++) begin
        applyStimulus(1'b1, 4'(c), 3'b000, 4'b0000, 1'b0, 4'b0000);
        @(negedge clk);
        if (sweepSet[k] == 4'b1001 && c == 10)
          checkOutput("ge_at_1001", {3'b0, cond_ex}, 4'b0001);
        if (sweepSet[k] == 4'b1001 && c == 11)
          checkOutput("lt_at_1001", {3'b0, cond_ex}, 4'b0000);
        if (sweepSet[k] == 4'b0010 && c == 8)
          checkOutput("hi_at_0010", {3'b0, cond_ex}, 4'b0001);
        step();
      end
      idle();
    end

    // MSR wins over flag_w, then an invalid MSR changes nothing
    setFlags(4'b0000);
    applyStimulus(1'b1, 4'b1110, 3'b111, 4'b1100, 1'b1, 4'b0011);
    step();
    idle();
    @(negedge clk);
    checkOutput("msr_flags", flags, 4'b0011);
    checkOutput("msr_carry", {3'b0, carry_out}, 4'b0001);
    step();
    applyStimulus(1'b0, 4'b1110, 3'b111, 4'b1100, 1'b1, 4'b1100);
    step();
    idle();
    @(negedge clk);
    checkOutput("msr_invalid_flags", flags, 4'b0011);
    step();

    // Reset in the same cycle as a pending flag write discards it
    setFlags(4'b0101);
    applyStimulus(1'b1, 4'b1110, 3'b111, 4'b1010, 1'b0, 4'b0000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_discard_now", flags, 4'b0000);
    step();
    checkOutput("reset_discard_edge", flags, 4'b0000);
    idle();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checkOutput("after_reset_flags", flags, 4'b0000);

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
